// File: rtl/ps_head_splitter_pkg.sv
// Shared helpers for the packet header splitter: index sizing and header-length saturation.
package ps_head_splitter_pkg;

    // The word index must be able to hold MAXLEN itself, where it saturates.
    function automatic int idx_width(input int maxlen);
        return $clog2(maxlen + 1);
    endfunction

    function automatic int sat_len(input int len, input int maxlen);
        return (len > maxlen - 1) ? maxlen - 1 : len;
    endfunction

endpackage

// File: rtl/ds_alt_scfifo.sv
// Header-entry buffer: single-clock show-ahead FIFO built on the payload FIFO core.
module ds_alt_scfifo #(
    parameter int    WIDTH   = 8,
    parameter int    DEPTH   = 16,
    parameter string RAMTYPE = "AUTO"
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             empty
);
    ps_alt_scfifo #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RAMTYPE (RAMTYPE)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .wr_dat (wr_dat),
        .full   (full),
        .rd_en  (rd_en),
        .rd_dat (rd_dat),
        .empty  (empty)
    );

endmodule

// File: rtl/ps_alt_scfifo.sv
// Single-clock show-ahead FIFO: rd_dat always shows the oldest entry; full/empty come from an occupancy count.
module ps_alt_scfifo #(
    parameter int    WIDTH   = 8,
    parameter int    DEPTH   = 16,
    parameter string RAMTYPE = "AUTO"
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok, rd_ok;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full   = (cnt_q == CW'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign wr_ok  = wr_en & ~full;
    assign rd_ok  = rd_en & ~empty;
    assign rd_dat = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ok ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd_ok ? next_ptr(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(wr_ok) - CW'(rd_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    generate
        if (RAMTYPE == "LOGIC") begin : g_flop_mem
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
                end else if (wr_ok) begin
                    mem[wr_ptr_q] <= wr_dat;
                end
            end
        end else begin : g_ram_mem
            // NOTE: RAM storage has no reset port, so contents stay undefined after reset; only the pointers and count are cleared, and empty entries are never read as valid.
            always_ff @(posedge clk) begin
                if (wr_ok) mem[wr_ptr_q] <= wr_dat;
            end
        end
    endgenerate

endmodule

// File: rtl/ps_head_capture.sv
// Per-packet word index, header-length latch and header accumulator; decides which accepted words go to each buffer.
// Header stripping is selected with the PS_HEAD_SPLITTER_STRIP_EN macro.
module ps_head_capture
    import ps_head_splitter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MAXLEN = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [$clog2(MAXLEN)-1:0]      i_len,
    input  logic [WIDTH-1:0]               i_dat,
    input  logic                           i_xfer,
    input  logic                           i_eop,
    output logic                           pay_push,
    output logic                           hdr_push,
    output logic [MAXLEN-1:0][WIDTH-1:0]   hdr,
    output logic [$clog2(MAXLEN)-1:0]      len,
    output logic                           short,
    output logic                           drop
);
    localparam int LW = $clog2(MAXLEN);
    localparam int IW = idx_width(MAXLEN);

    logic [IW-1:0]                idx_q, idx_d, cur_len;
    logic [LW-1:0]                len_q, len_d;
    logic [MAXLEN-1:0][WIDTH-1:0] acc_q, acc_d;

    // On the first word the latch is not loaded yet, so the live i_len applies.
    assign cur_len = (idx_q == '0) ? IW'(sat_len(int'(i_len), MAXLEN)) : IW'(len_q);

    always_comb begin
        // NOTE: every signal gets a default before any condition, so no path leaves a value unassigned and no latch is inferred.
        hdr   = acc_q;
        idx_d = idx_q;
        len_d = len_q;
        if (i_xfer && idx_q <= cur_len) hdr[idx_q[LW-1:0]] = i_dat;
        acc_d = (i_xfer && i_eop) ? '0 : hdr;
        if (i_xfer) begin
            if (idx_q == '0) len_d = cur_len[LW-1:0];
            if (i_eop) idx_d = '0;
            else if (idx_q != IW'(MAXLEN)) idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples its pre-edge inputs.
        if (reset) begin
            idx_q <= '0;
            len_q <= '0;
            acc_q <= '0;
        end else begin
            idx_q <= idx_d;
            len_q <= len_d;
            acc_q <= acc_d;
        end
    end

`ifdef PS_HEAD_SPLITTER_STRIP_EN
    logic done_q, done_d, drop_q, drop_d;

    // The index saturates, so a done flag keeps the header push to one per packet.
    always_comb begin
        pay_push = i_xfer && (idx_q > cur_len);
        hdr_push = pay_push && !done_q;
        len      = cur_len[LW-1:0];
        short    = 1'b0;
        done_d   = done_q;
        if (i_xfer) done_d = i_eop ? 1'b0 : (done_q | hdr_push);
        drop_d   = i_xfer && i_eop && (idx_q <= cur_len);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            done_q <= done_d;
            drop_q <= drop_d;
        end
    end

    assign drop = drop_q;
`else
    // A short packet pushes at its eop; the captured length is then the index reached.
    always_comb begin
        pay_push = i_xfer;
        short    = (idx_q < cur_len);
        hdr_push = i_xfer && ((idx_q == cur_len) || (i_eop && short));
        len      = idx_q[LW-1:0];
        drop     = 1'b0;
    end
`endif

endmodule

// File: rtl/ps_head_splitter.sv
// Packet header extractor: captures the first i_len+1 words of each packet and presents them beside every forwarded word.
// Defining PS_HEAD_SPLITTER_STRIP_EN removes header words from the forwarded stream.
module ps_head_splitter
    import ps_head_splitter_pkg::*;
#(
    parameter int    WIDTH   = 8,
    parameter int    MAXLEN  = 8,
    parameter int    DEPTH   = 16,
    parameter string RAMTYPE = "AUTO"
) (
    input  logic                         reset,
    input  logic                         clk,
    input  logic [$clog2(MAXLEN)-1:0]    i_len,
    input  logic [WIDTH-1:0]             i_dat,
    input  logic                         i_val,
    input  logic                         i_eop,
    output logic                         i_rdy,
    output logic [MAXLEN-1:0][WIDTH-1:0] o_hdr,
    output logic [$clog2(MAXLEN)-1:0]    o_len,
    output logic                         o_short,
    output logic                         o_drop,
    output logic [WIDTH-1:0]             o_dat,
    output logic                         o_val,
    output logic                         o_eop,
    input  logic                         o_rdy
);
    localparam int LW = $clog2(MAXLEN);

    typedef struct packed {
        logic [MAXLEN-1:0][WIDTH-1:0] hdr;
        logic [LW-1:0]                len;
        logic                         short;
    } hdr_entry_t;

    typedef struct packed {
        logic             eop;
        logic [WIDTH-1:0] dat;
    } pay_word_t;

    logic                         in_xfer, out_xfer;
    logic                         pay_push, hdr_push;
    logic                         pay_full, pay_empty, hdr_full, hdr_empty;
    logic [MAXLEN-1:0][WIDTH-1:0] cap_hdr;
    logic [LW-1:0]                cap_len;
    logic                         cap_short;
    hdr_entry_t                   cap_entry, hdr_head;
    pay_word_t                    pay_in, pay_head;

    assign i_rdy    = ~reset & ~pay_full & ~hdr_full;
    assign in_xfer  = i_val & i_rdy;
    assign o_val    = ~pay_empty & ~hdr_empty;
    assign out_xfer = o_val & o_rdy;

    assign cap_entry = '{hdr: cap_hdr, len: cap_len, short: cap_short};
    assign pay_in    = '{eop: i_eop, dat: i_dat};

    ps_head_capture #(
        .WIDTH  (WIDTH),
        .MAXLEN (MAXLEN)
    ) u_capture (
        .clk      (clk),
        .reset    (reset),
        .i_len    (i_len),
        .i_dat    (i_dat),
        .i_xfer   (in_xfer),
        .i_eop    (i_eop),
        .pay_push (pay_push),
        .hdr_push (hdr_push),
        .hdr      (cap_hdr),
        .len      (cap_len),
        .short    (cap_short),
        .drop     (o_drop)
    );

    ps_alt_scfifo #(
        .WIDTH   ($bits(pay_word_t)),
        .DEPTH   (DEPTH),
        .RAMTYPE (RAMTYPE)
    ) u_pay_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (pay_push),
        .wr_dat (pay_in),
        .full   (pay_full),
        .rd_en  (out_xfer),
        .rd_dat (pay_head),
        .empty  (pay_empty)
    );

    // The header entry retires with the last word of its packet.
    ds_alt_scfifo #(
        .WIDTH   ($bits(hdr_entry_t)),
        .DEPTH   (DEPTH),
        .RAMTYPE (RAMTYPE)
    ) u_hdr_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (hdr_push),
        .wr_dat (cap_entry),
        .full   (hdr_full),
        .rd_en  (out_xfer & pay_head.eop),
        .rd_dat (hdr_head),
        .empty  (hdr_empty)
    );

    // Empty buffers may hold stale or undefined entries, so outputs read zero until valid.
    assign o_hdr = hdr_empty ? '0 : hdr_head.hdr;
    assign o_len = hdr_empty ? '0 : hdr_head.len;
    assign o_dat = pay_empty ? '0 : pay_head.dat;
    assign o_eop = pay_empty ? 1'b0 : pay_head.eop;
`ifdef PS_HEAD_SPLITTER_STRIP_EN
    assign o_short = 1'b0;
`else
    assign o_short = hdr_empty ? 1'b0 : hdr_head.short;
`endif

endmodule

// File: doc/ps_head_splitter.md
# ps_head_splitter

Packet-stream header extractor with a per-packet programmable header length. Captures the first `i_len+1` words of each packet into a parallel header word. That header is presented alongside every outgoing word of the same packet. Optionally the header words are stripped from the forwarded stream. Sits between packet receivers and header-driven routers/classifiers in the PacketStream datapath.

## Interface
- `WIDTH`, 8, stream word width
- `MAXLEN`, 8, maximum header length in words (MAXLEN ≥ 2)
- `DEPTH`, 16, payload buffer depth in words and header buffer depth in entries (DEPTH ≥ MAXLEN+2)
- `RAMTYPE`, "AUTO", memory type for internal buffers

Ports:
- `reset`  in  1  reset, asynchronous, active-high
- `clk`  in  1  clock clk
- `i_len`  in  $clog2(MAXLEN)  header length minus 1; sampled on the first word of each packet
- `i_dat`  in  WIDTH  input word
- `i_val`  in  1  input valid
- `i_eop`  in  1  input end of packet
- `i_rdy`  out  1  input ready
- `o_hdr`  out  [MAXLEN-1:0][WIDTH-1:0]  header; word k of packet at index k; unused slots zero
- `o_len`  out  $clog2(MAXLEN)  captured header words minus 1
- `o_short`  out  1  packet ended before header length reached
- `o_drop`  out  1  one-cycle pulse: packet discarded (strip mode only)
- `o_dat`  out  WIDTH  output word
- `o_val`  out  1  output valid
- `o_eop`  out  1  output end of packet
- `o_rdy`  in  1  output ready

## Operation
- Input transfer: `i_val & i_rdy`. Output transfer: `o_val & o_rdy`.
- `i_rdy = pay_rdy & hdr_rdy`. Both buffers must have room.
- Length latch:
  - `len_reg` loads `i_len` on the first word of each packet (`idx == 0`).
  - Values above MAXLEN-1 saturate to MAXLEN-1.
  - The first word uses `i_len` directly.
- Word index `idx`, width `$clog2(MAXLEN+1)`:
  - Increments per transfer and saturates at MAXLEN.
  - Cleared on an eop transfer.
- Header accumulator: word at `idx ≤ len` is written into slot `idx`. The register is cleared on an eop transfer after the push. The push value includes the current word combinationally.
- Header entry `{hdr, len, short}` is pushed to the header buffer once per packet:
  - at the transfer with `idx == len`, with `short = 0`; or
  - at an eop transfer with `idx < len`, with `o_len = idx`, `short = 1`.
- All accepted words are written to the payload buffer.
- `o_val = pay_val & hdr_val`. The header buffer pops on an output transfer with `o_eop = 1`.
- Multiple complete packets may be queued, up to DEPTH headers.

## Timing
- Reset values:
  - `o_val`, `o_drop`, `o_short`, `o_eop` = 0; `o_hdr`, `o_len` = 0.
  - `i_rdy` = 0 while reset is asserted, 1 on the first cycle after.
- Latency: `o_val` rises no earlier than 1 cycle after the transfer that pushes the header entry.
  - Full length: first payload word out at earliest 1 cycle after header word `len` is accepted.
- `o_hdr`, `o_len`, `o_short` are stable for every word of a packet. They change only in the cycle after its eop output transfer.
- Boundary conditions:
  - Single-word packet, no strip: header pushed with `len = 0`, `short = 1` if `len_reg > 0`.
  - Header buffer full: `i_rdy = 0` even if the payload buffer has room. Never drop.
  - Payload buffer full: `i_rdy = 0`.
  - Simultaneous output pop and input push on the same buffer is permitted in the same cycle.
  - Reset mid-packet: buffers and state cleared; the next accepted word is the first of a packet.
- `o_rdy` may toggle freely. `o_dat`/`o_eop` hold while `o_val & ~o_rdy`.

## Configuration
- `PS_HEAD_SPLITTER_STRIP_EN` defined:
  - Words with `idx ≤ len` are not written to the payload buffer.
  - The header entry is pushed at the first payload word (`idx == len+1`), with `short = 0`.
  - A packet ending at `idx ≤ len` writes nothing to either buffer and pulses `o_drop` the cycle after its eop transfer.
  - `o_short` is tied 0.
- Not defined:
  - Full packet forwarded as described above.
  - `o_drop` tied 0.

## Structure
- Shared package `ps_head_splitter_pkg` holds:
  - a header entry struct typedef `{hdr, len, short}` parametrised via localparams of the module;
  - functions for `len` saturation and index width computation.
- Payload buffer: existing `ps_alt_scfifo`.
- Header buffer: existing `ds_alt_scfifo` with width `WIDTH*MAXLEN + $clog2(MAXLEN) + 1`.
- One natural sub-module, `ps_head_capture`, containing the index counter, length latch, accumulator and push logic.

## Test plan
- WIDTH=8, MAXLEN=4, i_len=2, packet 0x10..0x15, `o_rdy = 1`:
  - 6 output words; every beat carries `o_hdr = {0,0x12,0x11,0x10}`, `o_len = 2`, `o_short = 0`.
- i_len=3, 2-word packet 0xA0,0xA1:
  - `o_hdr = {0,0,0xA1,0xA0}`, `o_len = 1`, `o_short = 1`.
- STRIP_EN, i_len=1, packets {1,2,3,4} then {5,6}:
  - Output 3,4 with `o_hdr = {0,0,2,1}`.
  - Second packet produces no output words and one `o_drop` pulse.
- Back-to-back 3 packets with i_len=0,3,1 while `o_rdy = 0` for 20 cycles:
  - `i_rdy` deasserts when the buffers fill.
  - On release, each packet emerges intact with its own header and length.
- Random `i_val`/`o_rdy` with DEPTH=MAXLEN+2, 1000 packets:
  - No deadlock, no loss; headers match the scoreboard.
- Assert `reset` mid-packet after 2 words:
  - Outputs go to reset values.
  - The next packet is captured from index 0.
